// File: rtl/pcg_stream_if.sv
// pcg_stream_if
// Bundles the seed/stream/status signals of the PCG stream checker.
//   seed_load, seed_value : reseed the reference model (driven by master)
//   in_valid, in_data     : received generator word (driven by master)
//   in_ready              : checker accepts in_data this cycle (driven by slave)
//   expected              : word predicted for the next accepted transfer
//   match, mismatch       : one-cycle comparison result pulses
//   err_count, word_count : mismatch count (saturating) / compared words (wrapping)
//   fail                  : checker is in its FAIL state
interface pcg_stream_if;
    logic        seed_load;
    logic [63:0] seed_value;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] expected;
    logic        match;
    logic        mismatch;
    logic [15:0] err_count;
    logic [31:0] word_count;
    logic        fail;

    modport master (
        output seed_load, seed_value, in_valid, in_data,
        input  in_ready, expected, match, mismatch, err_count, word_count, fail
    );

    modport slave (
        input  seed_load, seed_value, in_valid, in_data,
        output in_ready, expected, match, mismatch, err_count, word_count, fail
    );
endinterface

// File: rtl/pcg_stream_checker.sv
// pcg_stream_checker
// Checks a stream of 32-bit words from a PCG-style generator against an
// internal 64-bit LCG reference model.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (checker returns to IDLE, S = 0)
//   bus  : pcg_stream_if.slave -- seed load, stream handshake, results
// The checker sits in IDLE until a seed is loaded, then compares every
// accepted word (RUN). Reaching ERR_LIMIT mismatches parks it in FAIL, where
// words are still drained but ignored, until the next seed load.
module pcg_stream_checker #(
    parameter logic [63:0] MULTIPLIER = 64'h5851f42d4c957f2d,
    parameter logic [63:0] INCREMENT  = 64'h14057b7ef767814f,
    parameter int unsigned ERR_LIMIT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    pcg_stream_if.slave  bus
);

    localparam logic [15:0] LIMIT = ERR_LIMIT[15:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] s_reg, s_next;
    logic [15:0] err_reg, err_next;
    logic [31:0] words_reg, words_next;
    logic        match_reg, match_next;
    logic        mismatch_reg, mismatch_next;

    logic        ready;
    logic        fail;
    logic        compare;
    logic        is_equal;
    logic [31:0] predicted;
    logic [15:0] err_inc;

    // Output word: low half of the state folded with its top 14 bits.
    assign predicted = s_reg[31:0] ^ {18'b0, s_reg[63:50]};
    assign is_equal  = (bus.in_data == predicted);
    // Only transfers accepted while running are compared; FAIL drains silently.
    assign compare   = bus.in_valid && ready && (state_reg == ST_RUN);
    assign err_inc   = (err_reg == 16'hFFFF) ? err_reg : err_reg + 16'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (bus.seed_load) begin
            state_next = ST_RUN;
        end else if (compare && !is_equal && (err_inc == LIMIT)) begin
            state_next = ST_FAIL;
        end
    end

    // FSM outputs: a seed load in the same cycle always blocks acceptance,
    // so a coinciding word is dropped rather than checked against stale state.
    always_comb begin
        ready = 1'b0;
        fail  = 1'b0;
        case (state_reg)
            ST_RUN:  ready = !bus.seed_load;
            ST_FAIL: begin
                ready = !bus.seed_load;
                fail  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // Model state, counters and result pulses
    always_comb begin
        s_next        = s_reg;
        err_next      = err_reg;
        words_next    = words_reg;
        match_next    = 1'b0;
        mismatch_next = 1'b0;
        if (bus.seed_load) begin
            s_next     = bus.seed_value;
            err_next   = 16'd0;
            words_next = 32'd0;
        end else if (compare) begin
            // The model advances on both outcomes so one bad word does not
            // desynchronise the rest of the stream.
            s_next        = s_reg * MULTIPLIER + INCREMENT;
            words_next    = words_reg + 32'd1;
            match_next    = is_equal;
            mismatch_next = !is_equal;
            if (!is_equal) begin
                err_next = err_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg        <= 64'd0;
            err_reg      <= 16'd0;
            words_reg    <= 32'd0;
            match_reg    <= 1'b0;
            mismatch_reg <= 1'b0;
        end else begin
            s_reg        <= s_next;
            err_reg      <= err_next;
            words_reg    <= words_next;
            match_reg    <= match_next;
            mismatch_reg <= mismatch_next;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.fail       = fail;
    assign bus.expected   = predicted;
    assign bus.match      = match_reg;
    assign bus.mismatch   = mismatch_reg;
    assign bus.err_count  = err_reg;
    assign bus.word_count = words_reg;

endmodule

// File: tb/tb_pcg_stream_checker.sv
// tb_pcg_stream_checker
// Self-checking bench for pcg_stream_checker: a constant vector table for the
// basic scenarios, hand-written sequences for FAIL/gap/async-reset cases, and
// a randomized run compared against an arithmetic reference model.
module tb_pcg_stream_checker;

    localparam logic [63:0] MULT  = 64'h5851f42d4c957f2d;
    localparam logic [63:0] INC   = 64'h14057b7ef767814f;
    localparam int          LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcg_stream_if bus();

    pcg_stream_checker #(
        .MULTIPLIER (MULT),
        .INCREMENT  (INC),
        .ERR_LIMIT  (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sl;
        logic [63:0] sv;
        logic        v;
        logic [31:0] d;
        logic        ready;
        logic        chk_exp;
        logic [31:0] exp_word;
        logic        m;
        logic        mm;
        logic [15:0] err;
        logic [31:0] wc;
        logic        f;
    } vec_t;

    vec_t tbl [9];

    // Reference model: plain 64-bit arithmetic and a few flags.
    longint unsigned m_s;
    bit              m_seeded;
    bit              m_failed;
    int              m_err;
    logic [31:0]     m_words;

    function automatic logic [31:0] model_word(input longint unsigned s);
        longint unsigned hi;
        hi = s >> 50;
        return s[31:0] ^ hi[31:0];
    endfunction

    function automatic longint unsigned model_next(input longint unsigned s);
        return s * MULT + INC;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic set_in(input logic sl, input logic [63:0] sv, input logic v, input logic [31:0] d);
        bus.seed_load  = sl;
        bus.seed_value = sv;
        bus.in_valid   = v;
        bus.in_data    = d;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_post(input string tag, input logic m, input logic mm,
                            input logic [15:0] err, input logic [31:0] wc, input logic f);
        chk({tag, "_match"},    bus.match,      m);
        chk({tag, "_mismatch"}, bus.mismatch,   mm);
        chk({tag, "_err"},      bus.err_count,  err);
        chk({tag, "_words"},    bus.word_count, wc);
        chk({tag, "_fail"},     bus.fail,       f);
    endtask

    task automatic rand_step(input bit sl, input logic [63:0] sv, input bit v, input logic [31:0] d);
        bit rdy;
        bit acc;
        bit em;
        bit emm;
        rdy = m_seeded && !sl;
        acc = v && rdy;
        em  = 1'b0;
        emm = 1'b0;
        set_in(sl, sv, v, d);
        #2;
        chk("rnd_ready",    bus.in_ready, rdy);
        chk("rnd_expected", bus.expected, model_word(m_s));
        if (sl) begin
            m_s      = sv;
            m_err    = 0;
            m_words  = 0;
            m_failed = 1'b0;
            m_seeded = 1'b1;
        end else if (acc && !m_failed) begin
            if (d == model_word(m_s)) begin
                em = 1'b1;
            end else begin
                emm = 1'b1;
                if (m_err != 65535) m_err++;
                if (m_err == LIMIT) m_failed = 1'b1;
            end
            m_words = m_words + 32'd1;
            m_s     = model_next(m_s);
        end
        edge1();
        chk_post("rnd", em, emm, 16'(m_err), m_words, m_failed);
    endtask

    initial begin
        longint unsigned s_loc;
        logic [31:0]     w;

        // Seed 0: S0 = 0 (word 0), S1 = INC (word 0xf767844e).
        tbl[0] = '{1'b1, 64'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 16'd0, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 64'h0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 16'd0, 32'd1, 1'b0};
        tbl[2] = '{1'b0, 64'h0, 1'b1, 32'hf767844e,  1'b1, 1'b1, 32'hf767844e,  1'b1, 1'b0, 16'd0, 32'd2, 1'b0};
        tbl[3] = '{1'b1, 64'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 16'd0, 32'd0, 1'b0};
        tbl[4] = '{1'b0, 64'h0, 1'b1, 32'h12345678,  1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 16'd1, 32'd1, 1'b0};
        tbl[5] = '{1'b0, 64'h0, 1'b1, 32'hf767844e,  1'b1, 1'b1, 32'hf767844e,  1'b1, 1'b0, 16'd1, 32'd2, 1'b0};
        tbl[6] = '{1'b1, 64'h0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 16'd0, 32'd0, 1'b0};
        tbl[7] = '{1'b0, 64'h0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 16'd0, 32'd1, 1'b0};
        tbl[8] = '{1'b0, 64'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hf767844e,  1'b0, 1'b0, 16'd0, 32'd1, 1'b0};

        set_in(1'b0, 64'h0, 1'b0, 32'h0);

        // Reset state while rst is held
        edge1();
        edge1();
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_expected", bus.expected, 32'h0);
        chk_post("rst", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        rst = 1'b0;

        // Stays idle after release without a seed, even with valid words
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 64'h0, 1'b1, 32'h0);
            #2;
            chk("idle_ready", bus.in_ready, 1'b0);
            edge1();
            chk_post("idle", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        end

        // Vector table: scenarios 1, 2 and 4
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].sl, tbl[i].sv, tbl[i].v, tbl[i].d);
            #2;
            chk($sformatf("vec%0d_ready", i), bus.in_ready, tbl[i].ready);
            if (tbl[i].chk_exp) chk($sformatf("vec%0d_expected", i), bus.expected, tbl[i].exp_word);
            edge1();
            chk_post($sformatf("vec%0d", i), tbl[i].m, tbl[i].mm, tbl[i].err, tbl[i].wc, tbl[i].f);
            $display("vec %0d sl=%0b v=%0b d=%08h -> match=%0b mismatch=%0b err=%0d words=%0d fail=%0b",
                     i, tbl[i].sl, tbl[i].v, tbl[i].d, bus.match, bus.mismatch,
                     bus.err_count, bus.word_count, bus.fail);
        end

        // Scenario 3: reach the error limit, drain in FAIL, then reseed
        set_in(1'b1, 64'h0, 1'b0, 32'h0);
        edge1();
        s_loc = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            w = ~model_word(s_loc);
            set_in(1'b0, 64'h0, 1'b1, w);
            #2;
            chk("lim_ready", bus.in_ready, 1'b1);
            edge1();
            s_loc = model_next(s_loc);
            chk_post($sformatf("lim%0d", i), 1'b0, 1'b1, 16'(i), 32'(i), (i == LIMIT) ? 1'b1 : 1'b0);
            $display("lim word %0d d=%08h -> mismatch=%0b err=%0d fail=%0b", i, w, bus.mismatch, bus.err_count, bus.fail);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 64'h0, 1'b1, model_word(s_loc));
            #2;
            chk("drain_ready", bus.in_ready, 1'b1);
            chk("drain_expected", bus.expected, model_word(s_loc));
            edge1();
            chk_post("drain", 1'b0, 1'b0, 16'(LIMIT), 32'(LIMIT), 1'b1);
            $display("drain word %0d -> match=%0b words=%0d fail=%0b", i, bus.match, bus.word_count, bus.fail);
        end
        set_in(1'b1, 64'h0, 1'b0, 32'h0);
        #2;
        chk("reseed_ready", bus.in_ready, 1'b0);
        edge1();
        chk_post("reseed", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        set_in(1'b0, 64'h0, 1'b0, 32'h0);
        #2;
        chk("reseed_run_ready", bus.in_ready, 1'b1);
        $display("reseed -> fail=%0b err=%0d ready=%0b", bus.fail, bus.err_count, bus.in_ready);

        // Scenario 5: gap of 5 idle cycles between the two words
        edge1();
        set_in(1'b0, 64'h0, 1'b1, 32'h0);
        edge1();
        chk_post("gap_w0", 1'b1, 1'b0, 16'd0, 32'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 64'h0, 1'b0, 32'h0);
            #2;
            chk("gap_expected", bus.expected, 32'hf767844e);
            edge1();
            chk_post("gap", 1'b0, 1'b0, 16'd0, 32'd1, 1'b0);
        end
        set_in(1'b0, 64'h0, 1'b1, 32'hf767844e);
        edge1();
        chk_post("gap_w1", 1'b1, 1'b0, 16'd0, 32'd2, 1'b0);
        $display("gap run -> match=%0b words=%0d", bus.match, bus.word_count);

        // Scenario 6: async reset between edges with a pulse pending
        set_in(1'b1, 64'h0, 1'b0, 32'h0);
        edge1();
        set_in(1'b0, 64'h0, 1'b1, 32'h12345678);
        edge1();
        chk_post("pre_rst", 1'b0, 1'b1, 16'd1, 32'd1, 1'b0);
        set_in(1'b0, 64'h0, 1'b1, 32'hf767844e);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", bus.in_ready, 1'b0);
        chk("arst_expected", bus.expected, 32'h0);
        chk_post("arst", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        edge1();
        chk_post("arst_edge", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        #2;
        rst = 1'b0;
        edge1();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("post_rst_ready", bus.in_ready, 1'b0);
            edge1();
            chk_post("post_rst", 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
        end
        $display("async reset -> ready=%0b match=%0b words=%0d", bus.in_ready, bus.match, bus.word_count);

        // Randomized run against the reference model, starting from IDLE
        m_s      = 0;
        m_seeded = 1'b0;
        m_failed = 1'b0;
        m_err    = 0;
        m_words  = 32'd0;
        for (int i = 0; i < 600; i++) begin
            bit          sl;
            bit          v;
            logic [63:0] sv;
            logic [31:0] d;
            sl = ($urandom_range(0, 29) == 0);
            v  = ($urandom_range(0, 3) != 0);
            sv = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            d  = ($urandom_range(0, 9) == 0) ? $urandom : model_word(m_s);
            rand_step(sl, sv, v, d);
            $display("rnd %0d sl=%0b v=%0b d=%08h -> match=%0b mismatch=%0b err=%0d words=%0d fail=%0b",
                     i, sl, v, d, bus.match, bus.mismatch, bus.err_count, bus.word_count, bus.fail);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcg_stream_checker.md
PCG_STREAM_CHECKER -- requirements
Module: pcg_stream_checker

Interface
REQ-001 The parameter MULTIPLIER SHALL default to 64'h5851f42d4c957f2d and is the LCG multiplier of the reference model.
REQ-002 The parameter INCREMENT SHALL default to 64'h14057b7ef767814f and is the LCG increment of the reference model.
REQ-003 The parameter ERR_LIMIT SHALL default to 16 and is the mismatch count (1..65535) at which the checker enters FAIL.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state is on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-high reset.
REQ-006 Port seed_load SHALL be an input, 1 bit wide, and loads seed_value into the model when sampled high.
REQ-007 Port seed_value SHALL be an input, 64 bits wide, and is the model state to load.
REQ-008 Port in_valid SHALL be an input, 1 bit wide, and marks in_data as a word from the generator under test.
REQ-009 Port in_ready SHALL be an output, 1 bit wide, and marks that the checker accepts in_data this cycle.
REQ-010 Port in_data SHALL be an input, 32 bits wide, and is the received generator output word.
REQ-011 Port expected SHALL be an output, 32 bits wide, and is the word the model predicts for the next accepted transfer.
REQ-012 Port match SHALL be an output, 1 bit wide, and is a one-cycle pulse for a compared word that was equal to expected.
REQ-013 Port mismatch SHALL be an output, 1 bit wide, and is a one-cycle pulse for a compared word that differed from expected.
REQ-014 Port err_count SHALL be an output, 16 bits wide, and is the saturating mismatch count.
REQ-015 Port word_count SHALL be an output, 32 bits wide, and is the wrapping count of compared words.
REQ-016 Port fail SHALL be an output, 1 bit wide, and is high while in the FAIL state.

Function
REQ-017 The model SHALL hold a 64-bit state S; expected = S[31:0] XOR {18'b0, S[63:50]}, combinational from S.
REQ-018 On each accepted transfer in RUN, S SHALL update to (S*MULTIPLIER + INCREMENT) mod 2^64; S SHALL hold on any cycle with no accepted transfer.
REQ-019 A transfer SHALL be accepted exactly when in_valid and in_ready are both high.
REQ-020 The FSM SHALL have the states IDLE, RUN and FAIL.
REQ-021 In IDLE, in_ready SHALL be 0.
REQ-022 In RUN, in_ready SHALL be NOT seed_load.
REQ-023 In FAIL, in_ready SHALL be NOT seed_load (drain mode).
REQ-024 seed_load in any state SHALL set S to seed_value, clear err_count and word_count, and put the FSM in RUN at the next edge.
REQ-025 When seed_load coincides with in_valid, the word SHALL be dropped: not compared, not counted, no pulse.
REQ-026 For each accepted word in RUN, in_data SHALL be compared against expected; match or mismatch SHALL pulse high for exactly the following cycle (latency 1), and word_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-027 On a mismatch, err_count SHALL increment and saturate at 0xFFFF.
REQ-028 When the increment makes err_count equal ERR_LIMIT, the FSM SHALL move from RUN to FAIL at the same edge.
REQ-029 The model SHALL advance on a mismatch as well as on a match, so a single corrupted word does not desynchronise the checker.
REQ-030 In FAIL, accepted words SHALL be discarded: S frozen, no pulses, counters frozen; fail = 1 until seed_load or rst.
REQ-031 Back-to-back transfers SHALL be supported at one word per clock.

Reset
REQ-032 While rst is high, regardless of clk, the FSM SHALL be IDLE, S SHALL be 0, and in_ready, match, mismatch, fail, err_count and word_count SHALL all be 0.
REQ-033 A reset asserted mid-stream SHALL discard the in-flight comparison, with no pulse after release.
REQ-034 After release, the checker SHALL remain in IDLE until seed_load.

Verification
REQ-035 Scenario 1: rst, then seed_load with seed_value 0, then words 0x00000000 and 0xf767844e on consecutive cycles -> two match pulses, err_count 0, word_count 2, fail 0.
REQ-036 Scenario 2: seed 0, then words 0x12345678 and 0xf767844e -> mismatch then match; err_count 1; word_count 2.
REQ-037 Scenario 3: ERR_LIMIT=4, seed 0, four wrong words -> fail high after the 4th; in_ready stays 1; further words produce no pulses and word_count stays at 4; a seed_load returns the FSM to RUN with fail=0 and err_count=0.
REQ-038 Scenario 4: seed_load and in_valid high in the same cycle -> in_ready 0, no pulse, word_count 0; the next word, 0x00000000, matches for seed 0.
REQ-039 Scenario 5: seed 0, in_valid low for 5 cycles between the two words of Scenario 1 -> expected holds at 0xf767844e during the gap and both words match.
REQ-040 Scenario 6: rst asserted asynchronously between clock edges mid-stream -> all outputs 0 before the next edge, and in_ready stays 0 after release until seed_load.
